vector_addsub_stream: RTL and testbench

Parametrised successor to the fixed 16-lane FP32 vector adder in the mm datapath.
- Computes LANES parallel FP32 add/subtract operations on wide vectors from the matrix unit.
- Uses valid/ready handshakes on both sides, a per-lane bypass mask and a sideband tag.
- A credit-controlled output FIFO absorbs the fixed-latency floating_point_add pipeline, so downstream backpressure never drops results.

---
 rtl/vector_addsub_stream.sv | 202 ++++++++++++++++++++
 tb/tb_vector_addsub_stream.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_addsub_stream.sv
// LANES-wide FP32 add/subtract stream: fixed-latency adder pipeline feeding a credit-controlled FWFT output FIFO.
// Optional macro VADD_RELU_EN clamps negative results in computed lanes to +0. floating_point_add is a behavioural stand-in for the vendor IP.

module floating_point_add #(
  parameter int LATENCY = 11
) (
  input  logic        aclk,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  output logic [31:0] m_axis_result_tdata
);

  // Round-to-nearest-even FP32 add with IEEE special-case handling; NaN results are canonical quiet NaN.
  function automatic logic [31:0] fp32_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [7:0]  ea, eb, d;
    logic [9:0]  e;
    logic [26:0] ma, mb;
    logic [27:0] s;
    logic [24:0] r;
    logic        sticky, rnd, x_nan, y_nan, x_inf, y_inf;
    x_nan = (&x[30:23]) && (|x[22:0]);
    y_nan = (&y[30:23]) && (|y[22:0]);
    x_inf = (&x[30:23]) && !(|x[22:0]);
    y_inf = (&y[30:23]) && !(|y[22:0]);
    if (x_nan || y_nan) return 32'h7FC00000;
    if (x_inf && y_inf) return (x[31] == y[31]) ? x : 32'h7FC00000;
    if (x_inf) return x;
    if (y_inf) return y;
    if (x[30:0] >= y[30:0]) begin
      a = x;
      b = y;
    end else begin
      a = y;
      b = x;
    end
    ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma = {a[30:23] != 8'd0, a[22:0], 3'b000};
    mb = {b[30:23] != 8'd0, b[22:0], 3'b000};
    d  = ea - eb;
    sticky = 1'b0;
    if (d >= 8'd27) begin
      sticky = |mb;
      mb = '0;
    end else begin
      for (int i = 0; i < 27; i++)
        if (i < int'(d)) sticky = sticky | mb[i];
      mb = mb >> d;
    end
    mb[0] = mb[0] | sticky;
    if (a[31] == b[31]) s = {1'b0, ma} + {1'b0, mb};
    else                s = {1'b0, ma} - {1'b0, mb};
    if (s == 28'd0) return {a[31] & b[31], 31'd0};
    e = {2'b00, ea};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end
    for (int i = 0; i < 26; i++)
      if (!s[26] && e > 10'd1) begin
        s = s << 1;
        e = e - 10'd1;
      end
    rnd = s[2] && (s[1] || s[0] || s[3]);
    r = {1'b0, s[26:3]} + {24'd0, rnd};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'd1;
    end
    if (e >= 10'd255) return {a[31], 8'hFF, 23'd0};
    return {a[31], r[23] ? e[7:0] : 8'h00, r[22:0]};
  endfunction

  logic [31:0] stage [LATENCY];

  always_ff @(posedge aclk) begin
    stage[0] <= (s_axis_a_tvalid && s_axis_b_tvalid) ? fp32_add(s_axis_a_tdata, s_axis_b_tdata) : 32'h0;
    for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
  end

  assign m_axis_result_tdata = stage[LATENCY-1];

endmodule

module vector_addsub_stream #(
  parameter int LANES       = 16,
  parameter int ADD_LATENCY = 11,
  parameter int FIFO_DEPTH  = 16,
  parameter int TAG_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*LANES-1:0]  in_a,
  input  logic [32*LANES-1:0]  in_b,
  input  logic                 in_mode,
  input  logic [LANES-1:0]     in_mask,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*LANES-1:0]  out_vec,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int W  = 32 * LANES;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic                 accept, wr_en, rd_en;
  logic [W-1:0]         wr_vec;
  logic [ADD_LATENCY-1:0] pipe_valid;
  logic [TAG_W-1:0]     pipe_tag  [ADD_LATENCY];
  logic [LANES-1:0]     pipe_mask [ADD_LATENCY];
  logic [W-1:0]         pipe_a    [ADD_LATENCY];
  logic [TAG_W+W-1:0]   mem       [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        fifo_count, inflight;
  logic [SW-1:0]        credit_sum;

  assign accept     = in_valid && in_ready;
  assign wr_en      = pipe_valid[ADD_LATENCY-1];
  assign rd_en      = out_valid && out_ready;
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
  assign in_ready   = !rst && (credit_sum < SW'(FIFO_DEPTH));
  assign out_valid  = (fifo_count != '0);
  assign {out_tag, out_vec} = out_valid ? mem[rd_ptr] : '0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [31:0] b_lane, sum, res;
    assign b_lane = {in_b[32*g+31] ^ in_mode, in_b[32*g +: 31]};

    floating_point_add #(.LATENCY(ADD_LATENCY)) u_add (
      .aclk                (clk),
      .s_axis_a_tvalid     (accept),
      .s_axis_a_tdata      (in_a[32*g +: 32]),
      .s_axis_b_tvalid     (accept),
      .s_axis_b_tdata      (b_lane),
      .m_axis_result_tdata (sum)
    );

`ifdef VADD_RELU_EN
    assign res = sum[31] ? 32'h0000_0000 : sum;
`else
    assign res = sum;
`endif
    assign wr_vec[32*g +: 32] = pipe_mask[ADD_LATENCY-1][g] ? res : pipe_a[ADD_LATENCY-1][32*g +: 32];
  end

  // Only the valid chain needs clearing; sideband data is don't-care while its valid bit is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < ADD_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0]  <= in_tag;
    pipe_mask[0] <= in_mask;
    pipe_a[0]    <= in_a;
    for (int i = 1; i < ADD_LATENCY; i++) begin
      pipe_tag[i]  <= pipe_tag[i-1];
      pipe_mask[i] <= pipe_mask[i-1];
      pipe_a[i]    <= pipe_a[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= {pipe_tag[ADD_LATENCY-1], wr_vec};
  end

  // Credits cover both results in the adder and results already buffered, so the FIFO cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      case ({accept, wr_en})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_addsub_stream.sv
// Directed self-checking bench for vector_addsub_stream: latency, add/sub, bypass mask, backpressure,
// streaming, mid-flight reset and the VADD_RELU_EN clamp, with hand-computed expected vectors.

module tb_vector_addsub_stream;

  localparam int LANES = 16;
  localparam int L     = 11;
  localparam int D     = 16;
  localparam int TW    = 8;
  localparam int W     = 32 * LANES;

  logic             clk, rst, in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [W-1:0]     in_a, in_b, out_vec;
  logic [LANES-1:0] in_mask;
  logic [TW-1:0]    in_tag, out_tag;

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  vec;
  } exp_t;

  exp_t exp_q[$];
  int   out_cycles[$];
  int   num_checks = 0;
  int   num_fails  = 0;
  int   cycle      = 0;
  int   out_count  = 0;

  vector_addsub_stream #(.LANES(LANES), .ADD_LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_mask   (in_mask),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [W-1:0] observed, input logic [W-1:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] splat(input logic [31:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[32*i +: 32] = v;
    return r;
  endfunction

  // Consumed outputs are checked in order against the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      out_count++;
      out_cycles.push_back(cycle);
      checkOutput("out_expected", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("out_tag", W'(out_tag), W'(e.tag));
        checkOutput("out_vec", out_vec, e.vec);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                               input logic [LANES-1:0] mask, input logic [TW-1:0] tag,
                               input logic [W-1:0] exp_vec);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_mask  = mask;
    in_tag   = tag;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    checkOutput("accept_ready", W'(in_ready), W'(1));
    if (in_ready) exp_q.push_back('{tag: tag, vec: exp_vec});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    checkOutput(name, W'(exp_q.size()), W'(0));
  endtask

  initial begin
    logic [W-1:0] va, vb, vx;
    logic [LANES-1:0] msk;
    int n, base, accepts, stalls, sent;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
    in_mask = '0; in_tag = '0; out_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_in_ready", W'(in_ready), W'(0));
    checkOutput("rst_out_valid", W'(out_valid), W'(0));
    checkOutput("rst_out_vec", out_vec, '0);
    checkOutput("rst_out_tag", W'(out_tag), W'(0));
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", W'(in_ready), W'(1));

    $display("[TB] Test 1: add all lanes, latency");
    base = out_count;
    applyStimulus(splat(32'h3F800000), splat(32'h40000000), 1'b0, '1, 8'h5A, splat(32'h40400000));
    n = 1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("t1_latency", W'(n), W'(L + 1));
    waitDrain("t1_drain", 50);
    checkOutput("t1_count", W'(out_count - base), W'(1));

    $display("[TB] Test 2: subtract with mask, bit-exact bypass");
    vx = splat(32'h40400000);
    vx[31:0] = 32'h40000000;
    applyStimulus(splat(32'h40400000), splat(32'h3F800000), 1'b1, 16'h0001, 8'h02, vx);
    va = splat(32'h3F800000);
    vx = splat(32'h40400000);
    msk = '1;
    va[63:32]   = 32'h7FC12345; vx[63:32]   = 32'h7FC12345; msk[1] = 1'b0;
    va[127:96]  = 32'h80000000; vx[127:96]  = 32'h80000000; msk[3] = 1'b0;
    va[511:480] = 32'hFF800001; vx[511:480] = 32'hFF800001; msk[15] = 1'b0;
    applyStimulus(va, splat(32'h40000000), 1'b0, msk, 8'h03, vx);
    waitDrain("t2_drain", 50);

    $display("[TB] Test 3: backpressure");
    base = out_count;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = splat(32'h3F800000); in_b = splat(32'h3F800000);
    in_mode = 1'b0; in_mask = '1;
    accepts = 0;
    for (int k = 0; k < 40; k++) begin
      in_tag = TW'(accepts);
      if (in_ready) begin
        exp_q.push_back('{tag: TW'(accepts), vec: splat(32'h40000000)});
        accepts++;
      end
      tick();
    end
    in_valid = 1'b0;
    checkOutput("t3_accepts", W'(accepts), W'(D));
    checkOutput("t3_in_ready_low", W'(in_ready), W'(0));
    checkOutput("t3_hold_valid", W'(out_valid), W'(1));
    checkOutput("t3_hold_tag", W'(out_tag), W'(0));
    tick();
    checkOutput("t3_hold_tag2", W'(out_tag), W'(0));
    checkOutput("t3_hold_vec", out_vec, splat(32'h40000000));
    out_ready = 1'b1;
    waitDrain("t3_drain", 100);
    checkOutput("t3_count", W'(out_count - base), W'(D));

    $display("[TB] Test 4: streaming");
    base = out_count;
    out_cycles.delete();
    in_valid = 1'b1; in_a = splat(32'h40400000); in_b = splat(32'h3F800000);
    in_mode = 1'b1; in_mask = '1;
    sent = 0; stalls = 0; n = 0;
    while (sent < 100 && n < 300) begin
      in_tag = TW'(sent);
      if (in_ready) begin
        exp_q.push_back('{tag: TW'(sent), vec: splat(32'h40000000)});
        sent++;
      end else begin
        stalls++;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    checkOutput("t4_stalls", W'(stalls), W'(0));
    waitDrain("t4_drain", 100);
    checkOutput("t4_count", W'(out_count - base), W'(100));
    if (out_cycles.size() == 100)
      checkOutput("t4_consecutive", W'(out_cycles[99] - out_cycles[0]), W'(99));
    else
      checkOutput("t4_cycles_recorded", W'(out_cycles.size()), W'(100));

    $display("[TB] Test 5: reset mid-flight");
    in_valid = 1'b1; in_a = splat(32'h3F800000); in_b = splat(32'h3F800000);
    in_mode = 1'b0; in_mask = '1;
    for (int k = 0; k < 4; k++) begin
      in_tag = TW'(k + 10);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    base = out_count;
    for (int k = 0; k < 2 * L; k++) tick();
    checkOutput("t5_no_output", W'(out_count - base), W'(0));
    checkOutput("t5_out_valid", W'(out_valid), W'(0));
    applyStimulus(splat(32'h3F800000), splat(32'h40000000), 1'b0, '1, 8'd77, splat(32'h40400000));
    waitDrain("t5_drain", 50);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("t5_count", W'(out_count - base), W'(1));

    $display("[TB] Test 6: negative result clamp");
`ifdef VADD_RELU_EN
    vx = splat(32'h00000000);
`else
    vx = splat(32'hC0000000);
`endif
    va = splat(32'h3F800000);
    va[31:0] = 32'hBF800000;
    vx[31:0] = 32'hBF800000;
    applyStimulus(va, splat(32'h40400000), 1'b1, 16'hFFFE, 8'h06, vx);
    waitDrain("t6_drain", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
